// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Purpose:
//   Cleans up one raw SPI pad input (SCLK, CS or MOSI) before the slave
//   control FSM sees it. The pad is first brought into the clk domain by a
//   two-flop synchronizer. A counter-based debouncer then accepts a new level
//   only once it has been stable for WAITTIME consecutive cycles. Finally,
//   registered one-cycle pulses mark each accepted rising or falling change.
//
// Parameters:
//   COUNTERWIDTH - width of the debounce counter
//   WAITTIME     - consecutive deviating cycles needed before the output
//                  level follows (1 .. 2**COUNTERWIDTH-1)
//   RESET_VALUE  - idle level of the pin (1 for CS, 0 otherwise)
//
// Ports:
//   clk          - system clock, all state changes on the rising edge
//   reset        - asynchronous, active-high reset
//   noisysignal  - raw pad input, asynchronous to clk, may bounce
//   conditioned  - synchronized, debounced level
//   positiveedge - one-cycle pulse in the first cycle conditioned is 1
//   negativeedge - one-cycle pulse in the first cycle conditioned is 0
// -----------------------------------------------------------------------------
module input_conditioner #(
  parameter int   COUNTERWIDTH = 3,
  parameter int   WAITTIME     = 3,
  parameter logic RESET_VALUE  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic noisysignal,
  output logic conditioned,
  output logic positiveedge,
  output logic negativeedge
);

  // The counter only ever reaches WAITTIME-1 before it is cleared, so the
  // terminal value is the only count the debouncer needs to recognise.
  localparam logic [COUNTERWIDTH-1:0] LAST_COUNT = COUNTERWIDTH'(WAITTIME - 1);
  localparam logic [COUNTERWIDTH-1:0] COUNT_ONE  = COUNTERWIDTH'(1);

  // A WAITTIME the counter cannot represent would make the output either
  // follow the raw input with no filtering or never update at all, so such a
  // build is stopped at elaboration.
  generate
    if (WAITTIME < 1 || WAITTIME > (1 << COUNTERWIDTH) - 1) begin : g_bad_waittime
      $error("input_conditioner: WAITTIME=%0d is outside 1..%0d",
             WAITTIME, (1 << COUNTERWIDTH) - 1);
    end
  endgenerate

  logic                    sync0;
  logic                    sync1;
  logic [COUNTERWIDTH-1:0] counter;

  // Two-flop synchronizer. sync0 may go metastable when the pad changes
  // close to a clock edge; only sync1, which has had a full cycle to settle,
  // is allowed to feed the debouncer. Both flops start at the pin's idle
  // level so that leaving reset never looks like a transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0 <= RESET_VALUE;
      sync1 <= RESET_VALUE;
    end else begin
      sync0 <= noisysignal;
      sync1 <= sync0;
    end
  end

  // Debouncer and edge detector. Any cycle in which the synchronized input
  // agrees with the accepted level throws away a partial count, so a glitch
  // shorter than WAITTIME cycles leaves no trace. When the count completes,
  // the new level is taken and the matching edge pulse is raised in the same
  // cycle; clearing the counter at that moment lets an opposite deviation
  // start counting straight away. Reset loads the idle level with no pulse,
  // so neither reset nor its release produces an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conditioned  <= RESET_VALUE;
      counter      <= '0;
      positiveedge <= 1'b0;
      negativeedge <= 1'b0;
    end else if (sync1 == conditioned) begin
      counter      <= '0;
      positiveedge <= 1'b0;
      negativeedge <= 1'b0;
    end else if (counter == LAST_COUNT) begin
      conditioned  <= sync1;
      counter      <= '0;
      positiveedge <= sync1;
      negativeedge <= ~sync1;
    end else begin
      counter      <= counter + COUNT_ONE;
      positiveedge <= 1'b0;
      negativeedge <= 1'b0;
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
//
// Purpose:
//   Self-checking bench for input_conditioner. Two instances share clock,
//   reset and pad input: dut index 0 idles low (MOSI/SCLK style) and dut
//   index 1 idles high (CS style), both with WAITTIME=3.
//
//   The reference model works on the history of pad samples: the debouncer
//   sees each sample two edges late, and the accepted level flips exactly
//   when the last WAITTIME delayed samples all disagree with it.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

  localparam int W = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       noisysignal = 1'b0;
  logic [1:0] cond;
  logic [1:0] pe;
  logic [1:0] ne;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state, one slot per instance.
  bit m_s0 [2];
  bit m_s1 [2];
  bit m_c  [2];
  bit m_pe [2];
  bit m_ne [2];
  bit m_hist [2][$];

  input_conditioner #(.COUNTERWIDTH(3), .WAITTIME(W), .RESET_VALUE(1'b0)) dut0 (
    .clk          (clk),
    .reset        (reset),
    .noisysignal  (noisysignal),
    .conditioned  (cond[0]),
    .positiveedge (pe[0]),
    .negativeedge (ne[0])
  );

  input_conditioner #(.COUNTERWIDTH(3), .WAITTIME(W), .RESET_VALUE(1'b1)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .noisysignal  (noisysignal),
    .conditioned  (cond[1]),
    .positiveedge (pe[1]),
    .negativeedge (ne[1])
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Model reset: everything at the idle level of the instance, no history.
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_s0[d] = (d == 1);
      m_s1[d] = (d == 1);
      m_c[d]  = (d == 1);
      m_pe[d] = 1'b0;
      m_ne[d] = 1'b0;
      m_hist[d].delete();
    end
  endtask

  // Model one rising edge with the pad value sampled at that edge.
  task automatic model_edge(input bit sample);
    bit seen;
    bit all_differ;
    for (int d = 0; d < 2; d++) begin
      seen    = m_s1[d];
      m_s1[d] = m_s0[d];
      m_s0[d] = sample;
      m_hist[d].push_back(seen);
      if (m_hist[d].size() > W) void'(m_hist[d].pop_front());
      m_pe[d] = 1'b0;
      m_ne[d] = 1'b0;
      if (m_hist[d].size() == W) begin
        all_differ = 1'b1;
        foreach (m_hist[d][i]) if (m_hist[d][i] == m_c[d]) all_differ = 1'b0;
        if (all_differ) begin
          m_c[d]  = ~m_c[d];
          m_pe[d] = m_c[d];
          m_ne[d] = ~m_c[d];
        end
      end
    end
  endtask

  // Drive the pad, take one rising edge, advance the model and return 1
  // time unit after the edge so outputs are sampled away from it.
  task automatic tick(input bit v);
    noisysignal = v;
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge(v);
    #1;
  endtask

  // Reset held with the pad high, then released: the idle-low instance must
  // rise with a single pulse at the 5th edge after release.
  task automatic test_reset();
    noisysignal = 1'b1;
    reset = 1'b1;
    model_reset();
    #2;
    vectors++;
    if (cond !== 2'b10 || pe !== 2'b00 || ne !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got cond=%b pe=%b ne=%b expected cond=10 pe=00 ne=00",
               cond, pe, ne);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if ({cond[d], pe[d], ne[d]} !== {m_c[d], m_pe[d], m_ne[d]}) begin
          miscompares++;
          $display("[TB] FAIL reset_hold dut%0d: got c/pe/ne=%b%b%b expected %b%b%b",
                   d, cond[d], pe[d], ne[d], m_c[d], m_pe[d], m_ne[d]);
        end
      end
    end
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick(1'b1);
      vectors++;
      if (cond[0] !== (i >= 5) || pe[0] !== (i == 5) || ne[0] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_release edge%0d: got c/pe/ne=%b%b%b expected %b%b0",
                 i, cond[0], pe[0], ne[0], (i >= 5), (i == 5));
      end
      vectors++;
      if (cond[1] !== 1'b1 || pe[1] !== 1'b0 || ne[1] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_release_cs edge%0d: got c/pe/ne=%b%b%b expected 100",
                 i, cond[1], pe[1], ne[1]);
      end
    end
  endtask

  // Settle low, then a clean 0->1 step: rise and pulse at edge 4 after the
  // first sampling edge (edge 0).
  task automatic test_clean_rise();
    for (int i = 0; i < 8; i++) begin
      tick(1'b0);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if ({cond[d], pe[d], ne[d]} !== {m_c[d], m_pe[d], m_ne[d]}) begin
          miscompares++;
          $display("[TB] FAIL settle_low dut%0d: got c/pe/ne=%b%b%b expected %b%b%b",
                   d, cond[d], pe[d], ne[d], m_c[d], m_pe[d], m_ne[d]);
        end
      end
    end
    for (int i = 0; i <= 6; i++) begin
      tick(1'b1);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (cond[d] !== (i >= 4) || pe[d] !== (i == 4) || ne[d] !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL clean_rise dut%0d edge%0d: got c/pe/ne=%b%b%b expected %b%b0",
                   d, i, cond[d], pe[d], ne[d], (i >= 4), (i == 4));
        end
      end
    end
  endtask

  // From a settled low level, a 2-cycle high glitch must be ignored.
  task automatic test_glitch();
    for (int i = 0; i < 8; i++) tick(1'b0);
    for (int i = 0; i < 20; i++) begin
      tick(i < 2);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (cond[d] !== 1'b0 || pe[d] !== 1'b0 || ne[d] !== 1'b0 ||
            {cond[d], pe[d], ne[d]} !== {m_c[d], m_pe[d], m_ne[d]}) begin
          miscompares++;
          $display("[TB] FAIL glitch dut%0d cycle%0d: got c/pe/ne=%b%b%b expected 000",
                   d, i, cond[d], pe[d], ne[d]);
        end
      end
    end
  endtask

  // Bounce 1,0,1,0,1 then hold 1: one pulse, 4 edges after the last toggle.
  task automatic test_bounce();
    int pulses [2];
    int where  [2];
    bit pattern [5];
    pattern = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int d = 0; d < 2; d++) begin
      pulses[d] = 0;
      where[d]  = -1;
    end
    for (int i = 0; i < 14; i++) begin
      tick(i < 5 ? pattern[i] : 1'b1);
      for (int d = 0; d < 2; d++) begin
        if (pe[d] === 1'b1) begin
          pulses[d]++;
          where[d] = i;
        end
        vectors++;
        if ({cond[d], pe[d], ne[d]} !== {m_c[d], m_pe[d], m_ne[d]}) begin
          miscompares++;
          $display("[TB] FAIL bounce_model dut%0d cycle%0d: got c/pe/ne=%b%b%b expected %b%b%b",
                   d, i, cond[d], pe[d], ne[d], m_c[d], m_pe[d], m_ne[d]);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (pulses[d] != 1 || where[d] != 4 + W + 1) begin
        miscompares++;
        $display("[TB] FAIL bounce_pulse dut%0d: got %0d pulses at edge %0d expected 1 at edge %0d",
                 d, pulses[d], where[d], 4 + W + 1);
      end
    end
  endtask

  // Reset with the pad high, let it settle, then drive 1->0: the CS-style
  // instance falls with one negativeedge and no positiveedge.
  task automatic test_cs_fall();
    noisysignal = 1'b1;
    reset = 1'b1;
    model_reset();
    tick(1'b1);
    tick(1'b1);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if ({cond[d], pe[d], ne[d]} !== {m_c[d], m_pe[d], m_ne[d]}) begin
          miscompares++;
          $display("[TB] FAIL cs_settle dut%0d: got c/pe/ne=%b%b%b expected %b%b%b",
                   d, cond[d], pe[d], ne[d], m_c[d], m_pe[d], m_ne[d]);
        end
      end
    end
    for (int i = 0; i <= 6; i++) begin
      tick(1'b0);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (cond[d] !== (i < 4) || ne[d] !== (i == 4) || pe[d] !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL cs_fall dut%0d edge%0d: got c/pe/ne=%b%b%b expected %b0%b",
                   d, i, cond[d], pe[d], ne[d], (i < 4), (i == 4));
        end
      end
    end
  endtask

  // Reset asserted between edges while a rise is being counted: outputs go
  // to the idle level at once with no pulse, and the count restarts cleanly.
  task automatic test_reset_midcount();
    tick(1'b0);
    tick(1'b0);
    tick(1'b1);
    tick(1'b1);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (cond !== 2'b10 || pe !== 2'b00 || ne !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL midcount_async: got cond=%b pe=%b ne=%b expected cond=10 pe=00 ne=00",
               cond, pe, ne);
    end
    tick(1'b1);
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick(1'b1);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if ({cond[d], pe[d], ne[d]} !== {m_c[d], m_pe[d], m_ne[d]}) begin
          miscompares++;
          $display("[TB] FAIL midcount_model dut%0d edge%0d: got c/pe/ne=%b%b%b expected %b%b%b",
                   d, i, cond[d], pe[d], ne[d], m_c[d], m_pe[d], m_ne[d]);
        end
      end
      vectors++;
      if (cond[0] !== (i >= 5) || pe[0] !== (i == 5) || ne[0] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL midcount_restart edge%0d: got c/pe/ne=%b%b%b expected %b%b0",
                 i, cond[0], pe[0], ne[0], (i >= 5), (i == 5));
      end
    end
  endtask

  // Random runs of 1..7 cycles per level: short runs must be filtered and
  // long runs accepted, back to back, exactly as the model predicts.
  task automatic test_random();
    bit lvl;
    int run;
    lvl = noisysignal;
    for (int r = 0; r < 80; r++) begin
      lvl = ~lvl;
      run = int'($urandom_range(1, 7));
      for (int i = 0; i < run; i++) begin
        tick(lvl);
        for (int d = 0; d < 2; d++) begin
          vectors++;
          if ({cond[d], pe[d], ne[d]} !== {m_c[d], m_pe[d], m_ne[d]} ||
              (pe[d] === 1'b1 && ne[d] === 1'b1)) begin
            miscompares++;
            $display("[TB] FAIL random dut%0d run%0d: got c/pe/ne=%b%b%b expected %b%b%b",
                     d, r, cond[d], pe[d], ne[d], m_c[d], m_pe[d], m_ne[d]);
          end
        end
      end
    end
  endtask

  // Scenarios run in sequence; each leaves the pad at a known level for the
  // next one.
  initial begin
    test_reset();
    test_clean_rise();
    test_glitch();
    test_bounce();
    test_cs_fall();
    test_reset_midcount();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
